// File: rtl/wb_mem_slave_pkg.sv
// Shared types for the Wishbone memory responder: FSM states,
// cycle/burst type codes and the burst address stepping helper.
package wb_mem_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    BURST
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Wrapping bursts step only the low bits; upper bits stay put.
  function automatic logic [31:0] next_beat_addr(
    input logic [31:0] addr,
    input logic [1:0]  bte
  );
    logic [31:0] n;
    n = addr;
    unique case (bte)
      BTE_LINEAR: n = addr + 32'd1;
      BTE_WRAP4:  n[1:0] = addr[1:0] + 2'd1;
      BTE_WRAP8:  n[2:0] = addr[2:0] + 3'd1;
      BTE_WRAP16: n[3:0] = addr[3:0] + 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 bus bundle with master and slave views.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   ADR;
  logic [DW-1:0]   DAT_W;
  logic [DW-1:0]   DAT_R;
  logic [DW/8-1:0] SEL;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic            CYC;
  logic            STB;
  logic            WE;
  logic            ACK;
  logic            ERR;

  modport slave (
    input  ADR, DAT_W, SEL, CTI, BTE, CYC, STB, WE,
    output DAT_R, ACK, ERR
  );

  modport master (
    output ADR, DAT_W, SEL, CTI, BTE, CYC, STB, WE,
    input  DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_mem_slave_ram.sv
// Byte-enabled single-port RAM, synchronous read-first,
// one cycle read latency. Contents are never reset.
module wb_mem_slave_ram #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [WB_DATA_WIDTH/8-1:0] sel_i,
  input  logic [MEM_ADDR_BITS-1:0]   addr_i,
  input  logic [WB_DATA_WIDTH-1:0]   wdata_i,
  output logic [WB_DATA_WIDTH-1:0]   rdata_o
);
  localparam int DEPTH = 1 << MEM_ADDR_BITS;
  localparam int NB    = WB_DATA_WIDTH / 8;

  logic [WB_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [WB_DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone B4 registered-feedback RAM responder (classic + bursts).
// WB_MEM_SLAVE_ERR_EN: out-of-range accesses answer with ERR.
module wb_mem_slave
  import wb_mem_slave_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input logic clk,
  input logic rstn,
  wb_if.slave s
);
  localparam int LSB = $clog2(WB_DATA_WIDTH / 8);

  typedef logic [MEM_ADDR_BITS-1:0] widx_t;

  state_e state_q, state_d;
  widx_t  beat_q, beat_d;
  logic   oor_q, oor_d;
  logic   vld_q, vld_d;

  logic [WB_DATA_WIDTH-1:0] dat_q, dat_r, rdata;

  logic        fire, hi, ack, err, adv, ram_we;
  widx_t       idx, nxt, ram_addr;
  logic [31:0] nxt_w;
  logic        nxt_ovf;
  logic        unused_bits;

  assign fire  = s.CYC & s.STB;
  assign idx   = s.ADR[MEM_ADDR_BITS+LSB-1:LSB];
  assign nxt_w = next_beat_addr(32'(beat_q), s.BTE);
  assign nxt   = nxt_w[MEM_ADDR_BITS-1:0];

`ifdef WB_MEM_SLAVE_ERR_EN
  assign hi      = |s.ADR[WB_ADDR_WIDTH-1:MEM_ADDR_BITS+LSB];
  assign nxt_ovf = nxt_w[MEM_ADDR_BITS];
`else
  assign hi      = 1'b0;
  assign nxt_ovf = 1'b0;
`endif

  assign unused_bits = ^{s.ADR, nxt_w};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      oor_q   <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      oor_q   <= oor_d;
      vld_q   <= vld_d;
      dat_q   <= dat_r;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    oor_d   = oor_q;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = FIRST;
          beat_d  = idx;
          oor_d   = hi;
        end
      end
      FIRST: begin
        if (!s.CYC) begin
          state_d = IDLE;
        end else if (s.STB) begin
          if (!oor_q && s.CTI == CTI_INCR) begin
            state_d = BURST;
            adv     = 1'b1;
            beat_d  = nxt;
            oor_d   = nxt_ovf;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BURST: begin
        if (!s.CYC) begin
          state_d = IDLE;
        end else if (ack | err) begin
          if (err || s.CTI == CTI_EOB) begin
            state_d = IDLE;
          end else begin
            adv    = 1'b1;
            beat_d = nxt;
            oor_d  = nxt_ovf;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write beats need no read data, so they skip the valid wait.
  always_comb begin
    ack = 1'b0;
    err = 1'b0;
    unique case (state_q)
      FIRST: begin
        ack = fire & ~oor_q;
        err = fire & oor_q;
      end
      BURST: begin
        ack = fire & ~oor_q & (vld_q | s.WE);
        err = fire & oor_q;
      end
      default: ;
    endcase
  end

  // A write occupies the port, so the read of the next beat waits.
  assign ram_we   = ack & s.WE;
  assign ram_addr = (state_q == IDLE)   ? idx :
                    (adv && !ram_we)    ? nxt : beat_q;
  assign vld_d    = ~ram_we;

  assign dat_r = ack ? rdata : (err ? '0 : dat_q);

  wb_mem_slave_ram #(
    .WB_DATA_WIDTH(WB_DATA_WIDTH),
    .MEM_ADDR_BITS(MEM_ADDR_BITS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .sel_i   (s.SEL),
    .addr_i  (ram_addr),
    .wdata_i (s.DAT_W),
    .rdata_o (rdata)
  );

  assign s.DAT_R = dat_r;
  assign s.ACK   = ack;
`ifdef WB_MEM_SLAVE_ERR_EN
  assign s.ERR   = err;
`else
  assign s.ERR   = 1'b0;
`endif

endmodule
